calc_input_seq: RTL

CALC_INPUT_SEQ -- requirements
Module: calc_input_seq

---
 rtl/calc_pkg.sv | 18 +
 rtl/key_conditioner.sv | 82 ++++++++
 rtl/calc_input_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator input sequencer.
//   state_t                 - sequencer FSM state (IDLE=00, OPND=01, SEND=10)
//   opcode_t                - 3-bit calculator opcode
//   DEFAULT_DEBOUNCE_CYCLES - default stable-cycle count for key debouncing
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OPND    = 2'b01,
        ST_SEND    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    typedef logic [2:0] opcode_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes one raw active-low pushbutton and turns each
// accepted press (high-to-low transition) into a single-cycle pulse.
// Optional feature macro: CALC_DEBOUNCE_EN. When defined, a level is accepted
// only after the synchronized input has differed from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles. When undefined, the press is simply the
// falling edge of the synchronized key.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   key_raw - raw active-low key level
//   press   - one-cycle pulse per accepted press
module key_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    // Parameter sanity check at elaboration.
    generate
        if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
            $error("key_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
        end
    endgenerate

    // Synchronizer resets to 1, i.e. key released.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end

    assign key_sync = sync_q[SYNC_STAGES-1];

`ifdef CALC_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic          accepted_q;
    logic          press_q;

    // Count consecutive cycles of disagreement; the cycle that completes the
    // run flips the accepted level and, for a falling level, raises press_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            accepted_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (key_sync == accepted_q) begin
                count_q <= '0;
            end else if (count_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                count_q    <= '0;
                accepted_q <= key_sync;
                press_q    <= ~key_sync;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign press = press_q;
`else
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b1;
        else        prev_q <= key_sync;
    end

    assign press = prev_q & ~key_sync;
`endif

endmodule

// File: rtl/calc_input_seq.sv
// calc_input_seq: collects operands and an opcode from switches/pushbuttons
// and presents them as one request to the calculator stage.
// Optional feature macro: CALC_DEBOUNCE_EN (enables key debouncing).
// Ports:
//   CLOCK_50  - clock, rising edge
//   RESET_N   - asynchronous active-low reset
//   KEY[2:0]  - raw active-low keys: [0] capture operands, [1] capture opcode, [2] clear
//   SW[7:0]   - raw switches: [7:4] operand A, [3:0] operand B, [2:0] opcode
//   A, B, OP  - captured request fields
//   out_valid - request valid (high exactly in SEND)
//   out_ready - downstream accepts the request
//   STATE     - current FSM state
//   TXN_COUNT - number of completed handshakes, wraps at 255
//
// Handshake: a request transfers on a rising edge where out_valid and
// out_ready are both high. Once raised, out_valid stays high and A/B/OP stay
// stable until that transfer, except that a clear press withdraws the request.
module calc_input_seq
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] OP,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] STATE,
    output logic [7:0] TXN_COUNT
);

    logic [2:0] press;

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
        u_key_opnd  (.clk(CLOCK_50), .rst_n(RESET_N), .key_raw(KEY[0]), .press(press[0]));
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
        u_key_op    (.clk(CLOCK_50), .rst_n(RESET_N), .key_raw(KEY[1]), .press(press[1]));
    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
        u_key_clear (.clk(CLOCK_50), .rst_n(RESET_N), .key_raw(KEY[2]), .press(press[2]));

    // Switch synchronizer; same depth as the keys so a press samples switch
    // values of the same age.
    logic [SYNC_STAGES-1:0][7:0] sw_q;
    logic [7:0]                  sw_sync;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) sw_q <= '1;
        else          sw_q <= {sw_q[SYNC_STAGES-2:0], SW};
    end

    assign sw_sync = sw_q[SYNC_STAGES-1];

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    opcode_t    op_q, op_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        // Clear wins over everything, including a handshake on the same edge.
        if (press[2]) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (press[0]) begin
                        a_d     = sw_sync[7:4];
                        b_d     = sw_sync[3:0];
                        state_d = ST_OPND;
                    end
                end
                ST_OPND: begin
                    // Operand capture shadows a simultaneous opcode press.
                    if (press[0]) begin
                        a_d = sw_sync[7:4];
                        b_d = sw_sync[3:0];
                    end else if (press[1]) begin
                        op_d    = sw_sync[2:0];
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign OP        = op_q;
    assign out_valid = (state_q == ST_SEND);
    assign STATE     = state_q;
    assign TXN_COUNT = cnt_q;

endmodule
